kf_spike_log_responder: RTL and testbench
=========================================

KF_SPIKE_LOG_RESPONDER -- requirements
Module: kf_spike_log_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64: ring capacity in 128-bit lines; power of two, at least 4.
REQ-002 SHALL have parameter NEURON_ID_BITS, default 8: width of the spike neuron ID.
REQ-003 SHALL use one clock, clk; reset rst_n is synchronous and active-low.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- log_enable  in  1  capture enable
- spike_valid  in  1  core output spike tap; no backpressure
- spike_neuron_id  in  NEURON_ID_BITS  post-synaptic ID
- spike_payload  in  8  spike payload
- log_flush  in  1  pulse: commit the partial line
- log_clear  in  1  pulse: empty the log
- mem_rd_valid  in  1  read request from the dream engine
- mem_rd_addr  in  32  byte address of the request
- mem_rd_ready  out  1  request accept
- mem_rd_data  out  128  read line
- mem_rd_data_valid  out  1  read response strobe
- line_count  out  clog2(DEPTH)+1  committed lines
- drop_count  out  16  dropped spikes; saturating
- log_full  out  1  line_count equals DEPTH

Function
REQ-005 SHALL accept a spike when spike_valid=1, log_enable=1, log_full=0 and log_clear=0; in all other cases the spike is not logged.
REQ-006 SHALL pack each accepted spike as a 32-bit record: [31:16] timestamp, [15:8] neuron ID (zero-extended or truncated to 8 bits), [7:0] payload.
REQ-007 SHALL place records into a packer line at slot k = bits [32k+31:32k], with k=0 for the first spike.
REQ-008 SHALL commit the line to the ring at the write pointer when the 4th record is packed, then increment line_count and the write pointer mod DEPTH, and reset the packer to empty.
REQ-009 SHALL treat log_flush as follows when log_full=0 and the packer holds 1-3 records: commit the line with unused slots set to zero.
REQ-010 SHALL treat log_flush as a no-op when the packer is empty or log_full=1.
REQ-011 SHALL, when a spike and log_flush arrive in the same cycle, pack the spike first, then commit once.
REQ-012 SHALL increment drop_count (saturating at 16'hFFFF) when spike_valid=1, log_enable=1 and log_full=1.
REQ-013 SHALL maintain the timestamp as a 16-bit free-running cycle counter that wraps 0xFFFF to 0.
REQ-014 SHALL hold mem_rd_ready=1 in every cycle after reset; a request is accepted when mem_rd_valid and mem_rd_ready are both 1.
REQ-015 SHALL decode the line index idx as mem_rd_addr[31:4]; mem_rd_addr[3:0] is ignored.
REQ-016 SHALL assert mem_rd_data_valid exactly 1 cycle after acceptance, with 1 response per request.
REQ-017 SHALL accept back-to-back requests every cycle.
REQ-018 SHALL return mem_rd_data = ring[(oldest+idx) mod DEPTH] when idx < line_count, where oldest is the oldest committed line.
REQ-019 SHALL return mem_rd_data = 0 when idx >= line_count.
REQ-020 SHALL hold mem_rd_data at 0 whenever mem_rd_data_valid=0.
REQ-021 SHALL, when a read and a commit occur in the same cycle, return pre-commit contents and use the pre-commit line_count.
REQ-022 SHALL, on log_clear, zero line_count, the pointers and the packer in the next cycle; log_clear wins over a spike or log_flush in the same cycle.
REQ-023 SHALL NOT let log_clear alter drop_count or an in-flight read response.
REQ-024 SHALL NOT let a ring wrap overwrite data: once log_full=1, only log_clear frees space.

Reset
REQ-025 SHALL, with rst_n=0 at a clk edge, set:
- mem_rd_ready=0, mem_rd_data_valid=0, mem_rd_data=0
- line_count=0, drop_count=0, log_full=0
- timestamp, pointers and packer to 0
REQ-026 SHALL NOT require ring storage contents to be reset; unread lines are never returned because of REQ-019.
REQ-027 SHALL discard a request accepted in the cycle that reset asserts, producing no response.

Configuration
REQ-028 SHALL, with KF_SPIKE_LOG_TS_EN defined, implement the timestamp counter and fill record bits [31:16] per REQ-006.
REQ-029 SHALL, without KF_SPIKE_LOG_TS_EN, omit the counter and write record bits [31:16] as 0; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover line packing:
- stimulus: after reset, 4 spikes (IDs 1,2,3,4; payloads 0x10,0x20,0x30,0x40) on consecutive cycles.
- response: line_count=1; reading addr 0x0 returns slot0[15:0]=0x0110 and slot3[15:0]=0x0440, with data_valid one cycle after acceptance.
REQ-031 SHALL cover flush:
- stimulus: 2 spikes, then log_flush.
- response: line_count=1; slots 2-3 read as 0.
REQ-032 SHALL cover overflow:
- stimulus: DEPTH*4 + 3 spikes.
- response: log_full=1, line_count=DEPTH, drop_count=3.
- stimulus: then log_clear.
- response: line_count=0, log_full=0, drop_count remains 3.
REQ-033 SHALL cover out-of-range and back-to-back reads:
- stimulus: line_count=2; reads to addr 0x20 and 0x10 on consecutive cycles.
- response: zero data, then line 1 data; data_valid high for 2 consecutive cycles.
REQ-034 SHALL cover simultaneous events:
- stimulus: spike together with log_clear.
- response: spike not logged and not counted in drop_count.
- stimulus: a 4th spike together with a read of idx 0.
- response: read returns 0 (pre-commit).
REQ-035 SHALL cover the configuration macro:
- with KF_SPIKE_LOG_TS_EN: spikes at cycles t and t+5 have a timestamp difference of 5.
- without it: timestamp bits read 0.

Source files
------------

// File: rtl/kf_spike_log_responder_if.sv
// Read port between the dream engine (master) and the spike log responder
// (slave). One request per cycle; the response strobe follows one cycle after
// acceptance and the data bus is zero whenever the strobe is low.
interface kf_spike_log_responder_if;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_ready;
    logic [127:0] mem_rd_data;
    logic         mem_rd_data_valid;

    modport master (
        output mem_rd_valid,
        output mem_rd_addr,
        input  mem_rd_ready,
        input  mem_rd_data,
        input  mem_rd_data_valid
    );

    modport slave (
        input  mem_rd_valid,
        input  mem_rd_addr,
        output mem_rd_ready,
        output mem_rd_data,
        output mem_rd_data_valid
    );
endinterface

// File: rtl/kf_spike_log_responder.sv
// kf_spike_log_responder: taps core output spikes, packs them four at a time
// into 128-bit lines and stores the lines in a non-overwriting ring that the
// dream engine reads back through a one-cycle-latency read port.
// Optional feature macro: KF_SPIKE_LOG_TS_EN -- when defined, a free-running
// 16-bit cycle counter stamps record bits [31:16]; otherwise they are zero.
// DEPTH must be a power of two and at least 4.
module kf_spike_log_responder #(
    parameter int DEPTH          = 64,
    parameter int NEURON_ID_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       log_enable,
    input  logic                       spike_valid,
    input  logic [NEURON_ID_BITS-1:0]  spike_neuron_id,
    input  logic [7:0]                 spike_payload,
    input  logic                       log_flush,
    input  logic                       log_clear,
    kf_spike_log_responder_if.slave    rd,
    output logic [$clog2(DEPTH):0]     line_count,
    output logic [15:0]                drop_count,
    output logic                       log_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------
    // Record formation
    // ------------------------------------------------------------------
    logic [7:0]  id8;
    logic [15:0] ts_value;
    logic [31:0] spike_record;

    generate
        if (NEURON_ID_BITS >= 8) begin : g_id_trunc
            assign id8 = spike_neuron_id[7:0];
            if (NEURON_ID_BITS > 8) begin : g_id_hi
                logic unused_id_hi;
                assign unused_id_hi = ^spike_neuron_id[NEURON_ID_BITS-1:8];
            end
        end else begin : g_id_ext
            assign id8 = {{(8-NEURON_ID_BITS){1'b0}}, spike_neuron_id};
        end
    endgenerate

`ifdef KF_SPIKE_LOG_TS_EN
    logic [15:0] ts_reg;

    // Free-running timestamp; wraps naturally from 0xFFFF to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 16'd1;
        end
    end

    assign ts_value = ts_reg;
`else
    assign ts_value = 16'd0;
`endif

    assign spike_record = {ts_value, id8, spike_payload};

    // ------------------------------------------------------------------
    // Packer and ring bookkeeping
    // ------------------------------------------------------------------
    logic [127:0]  pack_line_reg, pack_line_next;
    logic [1:0]    pack_cnt_reg,  pack_cnt_next;
    logic [AW-1:0] wr_ptr_reg,    wr_ptr_next;
    logic [CW-1:0] line_count_reg, line_count_next;
    logic [15:0]   drop_count_reg, drop_count_next;

    logic         full_int;
    logic         spike_accept;
    logic         spike_drop;
    logic         pack_has_data;
    logic         commit;
    logic [127:0] pack_merged;

    assign full_int      = (line_count_reg == CW'(DEPTH));
    assign spike_accept  = spike_valid & log_enable & ~full_int & ~log_clear;
    assign spike_drop    = spike_valid & log_enable & full_int;
    assign pack_has_data = spike_accept | (pack_cnt_reg != 2'd0);

    // The incoming record is merged into the slot selected by the packer
    // count, so a spike arriving with a flush lands before the commit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign pack_merged[32*gi +: 32] =
                (spike_accept && pack_cnt_reg == 2'(gi)) ? spike_record
                                                         : pack_line_reg[32*gi +: 32];
        end
    endgenerate

    // A line is committed on the fourth record or on a flush with 1-3
    // records held; clear overrides both, and a full ring blocks both.
    assign commit = ~log_clear & ~full_int &
                    ((spike_accept & (pack_cnt_reg == 2'd3)) |
                     (log_flush & pack_has_data));

    // Next-state for packer, write pointer and line count.
    always_comb begin
        pack_line_next  = pack_line_reg;
        pack_cnt_next   = pack_cnt_reg;
        wr_ptr_next     = wr_ptr_reg;
        line_count_next = line_count_reg;
        if (log_clear) begin
            pack_line_next  = '0;
            pack_cnt_next   = '0;
            wr_ptr_next     = '0;
            line_count_next = '0;
        end else if (commit) begin
            pack_line_next  = '0;
            pack_cnt_next   = '0;
            wr_ptr_next     = wr_ptr_reg + AW'(1);
            line_count_next = line_count_reg + CW'(1);
        end else if (spike_accept) begin
            pack_line_next  = pack_merged;
            pack_cnt_next   = pack_cnt_reg + 2'd1;
        end
    end

    // Dropped-spike counter saturates and is untouched by clear.
    always_comb begin
        drop_count_next = drop_count_reg;
        if (spike_drop && drop_count_reg != 16'hFFFF) begin
            drop_count_next = drop_count_reg + 16'd1;
        end
    end

    // Register the log bookkeeping state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_line_reg  <= '0;
            pack_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            line_count_reg <= '0;
            drop_count_reg <= '0;
        end else begin
            pack_line_reg  <= pack_line_next;
            pack_cnt_reg   <= pack_cnt_next;
            wr_ptr_reg     <= wr_ptr_next;
            line_count_reg <= line_count_next;
            drop_count_reg <= drop_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Ring storage (block RAM, registered read, no reset on contents)
    // ------------------------------------------------------------------
    logic [127:0] ring_mem [DEPTH];
    logic [127:0] ram_q_reg;
    logic         ring_we;

    assign ring_we = commit & rst_n;

    // Ring write port: one committed line per cycle at the write pointer.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring_mem[wr_ptr_reg] <= pack_merged;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    logic          ready_reg;
    logic          rsp_valid_reg;
    logic          rsp_hit_reg;
    logic          rd_accept;
    logic          rd_in_range;
    logic [27:0]   rd_idx;
    logic [AW-1:0] oldest_ptr;
    logic [AW-1:0] rd_ptr;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^rd.mem_rd_addr[3:0];
    assign rd_idx      = rd.mem_rd_addr[31:4];
    assign rd_accept   = rd.mem_rd_valid & ready_reg;
    // Range check uses the pre-commit count; the line being written this
    // cycle is never inside the readable range, so no read/write collision.
    assign rd_in_range = (rd_idx < 28'(line_count_reg));
    // When full, line_count truncates to 0 and oldest equals the write pointer.
    assign oldest_ptr  = wr_ptr_reg - line_count_reg[AW-1:0];
    assign rd_ptr      = oldest_ptr + rd_idx[AW-1:0];

    // Ring read port: registered read, gated to zero on miss below.
    always_ff @(posedge clk) begin
        ram_q_reg <= ring_mem[rd_ptr];
    end

    // Response strobe and hit flag; clear does not disturb them, reset does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_hit_reg   <= 1'b0;
        end else begin
            ready_reg     <= 1'b1;
            rsp_valid_reg <= rd_accept;
            rsp_hit_reg   <= rd_accept & rd_in_range;
        end
    end

    assign rd.mem_rd_ready      = ready_reg;
    assign rd.mem_rd_data_valid = rsp_valid_reg;
    assign rd.mem_rd_data       = rsp_hit_reg ? ram_q_reg : '0;

    assign line_count = line_count_reg;
    assign drop_count = drop_count_reg;
    assign log_full   = full_int;

endmodule

// File: tb/tb_kf_spike_log_responder.sv
// Self-checking bench for kf_spike_log_responder: directed scenarios followed
// by randomized traffic, all compared against a queue-based log model.
module tb_kf_spike_log_responder;

    localparam int DEPTH = 16;
    localparam int NB    = 10;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          log_enable;
    logic          spike_valid;
    logic [NB-1:0] spike_neuron_id;
    logic [7:0]    spike_payload;
    logic          log_flush;
    logic          log_clear;
    logic [CW-1:0] line_count;
    logic [15:0]   drop_count;
    logic          log_full;

    kf_spike_log_responder_if rd_bus();

    kf_spike_log_responder #(
        .DEPTH          (DEPTH),
        .NEURON_ID_BITS (NB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .log_enable      (log_enable),
        .spike_valid     (spike_valid),
        .spike_neuron_id (spike_neuron_id),
        .spike_payload   (spike_payload),
        .log_flush       (log_flush),
        .log_clear       (log_clear),
        .rd              (rd_bus),
        .line_count      (line_count),
        .drop_count      (drop_count),
        .log_full        (log_full)
    );

    // Reference model: committed lines oldest-first, pending records, counters.
    logic [127:0] m_lines [$];
    logic [31:0]  m_pend  [$];
    int           m_drop;
    logic [15:0]  m_ts;
    bit           m_ready;

    int           checks;
    int           failures;
    logic [127:0] last_rd_data;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n_cycles, input bit rv);
        rst_n = 1'b0;
        spike_valid = 1'b0; log_flush = 1'b0; log_clear = 1'b0;
        rd_bus.mem_rd_valid = rv;
        rd_bus.mem_rd_addr  = 32'h0;
        repeat (n_cycles) @(posedge clk);
        #1;
        m_lines.delete(); m_pend.delete();
        m_drop = 0; m_ts = 16'h0; m_ready = 1'b0;
        check_val("rst_ready", rd_bus.mem_rd_ready, 0);
        check_val("rst_dvalid", rd_bus.mem_rd_data_valid, 0);
        check_val("rst_data", rd_bus.mem_rd_data, 0);
        check_val("rst_lines", line_count, 0);
        check_val("rst_drops", drop_count, 0);
        check_val("rst_full", log_full, 0);
        rst_n = 1'b1;
        rd_bus.mem_rd_valid = 1'b0;
        $display("reset: %0d cycles, read_during_reset=%0d", n_cycles, rv);
    endtask

    // One clock cycle of stimulus, model update and output comparison.
    task automatic cycle(input bit sv, input bit en, input logic [NB-1:0] id,
                         input logic [7:0] pl, input bit fl, input bit cl,
                         input bit rv, input logic [31:0] addr);
        logic [27:0]  idx;
        logic [127:0] line;
        logic [127:0] exp_data;
        logic [15:0]  ts_field;
        bit           exp_valid;
        bit           full;
        spike_valid = sv; log_enable = en; spike_neuron_id = id; spike_payload = pl;
        log_flush = fl; log_clear = cl;
        rd_bus.mem_rd_valid = rv; rd_bus.mem_rd_addr = addr;

        idx       = addr[31:4];
        exp_valid = rv && m_ready;
        exp_data  = '0;
        if (exp_valid && idx < m_lines.size()) exp_data = m_lines[idx];
`ifdef KF_SPIKE_LOG_TS_EN
        ts_field = m_ts;
`else
        ts_field = 16'h0;
`endif
        full = (m_lines.size() == DEPTH);
        if (sv && en && full && m_drop < 65535) m_drop++;
        if (cl) begin
            m_lines.delete();
            m_pend.delete();
        end else begin
            if (sv && en && !full) m_pend.push_back({ts_field, id[7:0], pl});
            if (m_pend.size() == 4 || (fl && m_pend.size() > 0)) begin
                line = '0;
                foreach (m_pend[k]) line[32*k +: 32] = m_pend[k];
                m_lines.push_back(line);
                m_pend.delete();
            end
        end

        @(posedge clk);
        #1;
        m_ts++;
        m_ready = 1'b1;

        check_val("ready", rd_bus.mem_rd_ready, 1);
        check_val("dvalid", rd_bus.mem_rd_data_valid, exp_valid);
        check_val("rdata", rd_bus.mem_rd_data, exp_data);
        check_val("line_count", line_count, m_lines.size());
        check_val("drop_count", drop_count, m_drop);
        check_val("log_full", log_full, m_lines.size() == DEPTH);
        last_rd_data = rd_bus.mem_rd_data;
        $display("cyc sv=%0d en=%0d id=%03h pl=%02h fl=%0d cl=%0d rv=%0d addr=%08h | dv=%0d lc=%0d dc=%0d full=%0d",
                 sv, en, id, pl, fl, cl, rv, addr, rd_bus.mem_rd_data_valid, line_count, drop_count, log_full);
    endtask

    task automatic spike(input logic [NB-1:0] id, input logic [7:0] pl);
        cycle(1, 1, id, pl, 0, 0, 0, 32'h0);
    endtask
    task automatic idle();
        cycle(0, 1, '0, 8'h0, 0, 0, 0, 32'h0);
    endtask
    task automatic read(input logic [31:0] addr);
        cycle(0, 1, '0, 8'h0, 0, 0, 1, addr);
    endtask
    task automatic flush();
        cycle(0, 1, '0, 8'h0, 1, 0, 0, 32'h0);
    endtask
    task automatic clear();
        cycle(0, 1, '0, 8'h0, 0, 1, 0, 32'h0);
    endtask

    initial begin
        checks = 0; failures = 0;
        log_enable = 1'b1; spike_valid = 1'b0; spike_neuron_id = '0; spike_payload = 8'h0;
        log_flush = 1'b0; log_clear = 1'b0; rst_n = 1'b0;
        rd_bus.mem_rd_valid = 1'b0; rd_bus.mem_rd_addr = 32'h0;

        do_reset(3, 1'b1);
        idle();

        // Line packing: four spikes make one line.
        for (int i = 1; i <= 4; i++) spike(NB'(i), 8'(i * 16));
        read(32'h0);
        check_val("pack_lines", line_count, 1);
        check_val("pack_slot0", last_rd_data[15:0], 16'h0110);
        check_val("pack_slot3", last_rd_data[111:96], 16'h0440);

        // Flush of a partial line.
        clear();
        spike(NB'(5), 8'h55);
        spike(NB'(6), 8'h66);
        flush();
        read(32'h0);
        check_val("flush_lines", line_count, 1);
        check_val("flush_pad", last_rd_data[127:64], 0);

        // Overflow and clear.
        clear();
        for (int i = 0; i < DEPTH * 4 + 3; i++) spike(NB'($urandom_range(0, 1023)), 8'($urandom));
        check_val("ovf_full", log_full, 1);
        check_val("ovf_lines", line_count, DEPTH);
        check_val("ovf_drops", drop_count, 3);
        for (int i = 0; i < DEPTH + 2; i++) read(32'(i) << 4);
        clear();
        check_val("clr_lines", line_count, 0);
        check_val("clr_full", log_full, 0);
        check_val("clr_drops", drop_count, 3);

        // Out-of-range then in-range back-to-back reads.
        for (int i = 0; i < 8; i++) spike(NB'(i + 32), 8'($urandom));
        read(32'h20);
        check_val("oor_zero", last_rd_data, 0);
        read(32'h10);
        check_val("b2b_line1", last_rd_data, m_lines[1]);

        // Spike with clear, then 4th spike with a read of idx 0.
        clear();
        cycle(1, 1, NB'(9), 8'h99, 0, 1, 0, 32'h0);
        check_val("spkclr_lines", line_count, 0);
        check_val("spkclr_drops", drop_count, 3);
        for (int i = 0; i < 3; i++) spike(NB'(i), 8'(i));
        cycle(1, 1, NB'(3), 8'h3, 0, 0, 1, 32'h0);
        check_val("precommit_rd", last_rd_data, 0);
        check_val("postcommit_lc", line_count, 1);

        // Timestamp spacing.
        clear();
        spike(NB'(1), 8'h1);
        repeat (4) idle();
        spike(NB'(2), 8'h2);
        flush();
        read(32'h0);
`ifdef KF_SPIKE_LOG_TS_EN
        check_val("ts_delta", 16'(last_rd_data[63:48] - last_rd_data[31:16]), 5);
`else
        check_val("ts_zero0", last_rd_data[31:16], 0);
        check_val("ts_zero1", last_rd_data[63:48], 0);
`endif

        // Randomized traffic.
        clear();
        for (int i = 0; i < 2500; i++) begin
            cycle($urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 90,
                  NB'($urandom_range(0, 1023)),
                  8'($urandom),
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 999) < 4,
                  $urandom_range(0, 99) < 40,
                  (32'($urandom_range(0, DEPTH + 3)) << 4) | 32'($urandom_range(0, 15)));
        end

        // A request accepted on the reset edge yields no response.
        do_reset(1, 1'b1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
